// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational ROM address and
// registers the fetched word toward the decoder under a valid/ready handshake.
module fetch_unit #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 24,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              branch_en,
   input  logic [ADDR_W-1:0] branch_off,
   input  logic              halt,
   output logic              halted
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              valid_q, valid_d;
   logic              slot_free;

   assign slot_free = !valid_q || instr_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      if (jump_en) begin
         // Absolute redirect works from either state and drops whatever is held.
         pc_d    = jump_addr;
         valid_d = 1'b0;
         state_d = RUN;
      end else if (state_q == RUN) begin
         if (branch_en && valid_q) begin
            pc_d    = instr_pc_q + branch_off;
            valid_d = 1'b0;
         end else if (halt) begin
            state_d = HALTED;
            if (instr_ready) valid_d = 1'b0;
         end else if (slot_free) begin
            instr_d    = rom_data;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + ADDR_W'(1);
         end
      end else begin
         // Halted: only drain a pending instruction, never fetch.
         if (valid_q && instr_ready) valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
      end
   end

   assign rom_addr    = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a ROM that returns C00000|addr.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rom_addr;
   logic [23:0] rom_data;
   logic [23:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump_en;
   logic [7:0]  jump_addr;
   logic        branch_en;
   logic [7:0]  branch_off;
   logic        halt;
   logic        halted;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rom_data = 24'hC00000 | {16'h0, rom_addr};

   fetch_unit #(.ADDR_W(8), .DATA_W(24), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .jump_en(jump_en), .jump_addr(jump_addr),
      .branch_en(branch_en), .branch_off(branch_off), .halt(halt), .halted(halted)
   );

   typedef struct {
      logic        rst, rdy, jen;
      logic [7:0]  ja;
      logic        ben;
      logic [7:0]  bo;
      logic        hlt;
      logic [23:0] e_instr;
      logic [7:0]  e_ipc;
      logic        e_v, e_h;
      logic [7:0]  e_ra;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic r, logic rd, logic je, logic [7:0] ja, logic be,
                               logic [7:0] bo, logic h, logic [23:0] ei, logic [7:0] ep,
                               logic ev, logic eh, logic [7:0] ea);
      vec_t x;
      x.rst = r; x.rdy = rd; x.jen = je; x.ja = ja; x.ben = be; x.bo = bo; x.hlt = h;
      x.e_instr = ei; x.e_ipc = ep; x.e_v = ev; x.e_h = eh; x.e_ra = ea;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rd, input logic je, input logic [7:0] ja,
                        input logic be, input logic [7:0] bo, input logic h);
      @(negedge clk);
      rst = r; instr_ready = rd; jump_en = je; jump_addr = ja;
      branch_en = be; branch_off = bo; halt = h;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [23:0] ei, input logic [7:0] ep,
                             input logic ev, input logic eh, input logic [7:0] ea);
      chk({tag, ".instr"},    32'(instr),       32'(ei));
      chk({tag, ".instr_pc"}, 32'(instr_pc),    32'(ep));
      chk({tag, ".valid"},    32'(instr_valid), 32'(ev));
      chk({tag, ".halted"},   32'(halted),      32'(eh));
      chk({tag, ".rom_addr"}, 32'(rom_addr),    32'(ea));
   endtask

   initial begin
      rst = 1'b1; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
      branch_en = 1'b0; branch_off = '0; halt = 1'b0;

      //           rst rdy je ja     be bo     h  instr       ipc    v  h  rom
      vq.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 24'h000000, 8'h00, 0, 0, 8'h00));
      vq.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 24'h000000, 8'h00, 0, 0, 8'h00));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00000, 8'h00, 1, 0, 8'h01));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00001, 8'h01, 1, 0, 8'h02));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00002, 8'h02, 1, 0, 8'h03));
      // backpressure: 3 stalled cycles then release
      vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 24'hC00002, 8'h02, 1, 0, 8'h03));
      vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 24'hC00002, 8'h02, 1, 0, 8'h03));
      vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 24'hC00002, 8'h02, 1, 0, 8'h03));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00003, 8'h03, 1, 0, 8'h04));
      // jump F0: one bubble then target
      vq.push_back(mk(0, 1, 1, 8'hF0, 0, 8'h00, 0, 24'hC00003, 8'h03, 0, 0, 8'hF0));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC000F0, 8'hF0, 1, 0, 8'hF1));
      // jump FE and wrap through FF -> 00
      vq.push_back(mk(0, 1, 1, 8'hFE, 0, 8'h00, 0, 24'hC000F0, 8'hF0, 0, 0, 8'hFE));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC000FE, 8'hFE, 1, 0, 8'hFF));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC000FF, 8'hFF, 1, 0, 8'h00));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00000, 8'h00, 1, 0, 8'h01));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00001, 8'h01, 1, 0, 8'h02));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00002, 8'h02, 1, 0, 8'h03));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00003, 8'h03, 1, 0, 8'h04));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00004, 8'h04, 1, 0, 8'h05));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00005, 8'h05, 1, 0, 8'h06));
      // branch -3 from instr_pc 5 -> 2
      vq.push_back(mk(0, 1, 0, 8'h00, 1, 8'hFD, 0, 24'hC00005, 8'h05, 0, 0, 8'h02));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00002, 8'h02, 1, 0, 8'h03));
      // jump beats branch in the same cycle
      vq.push_back(mk(0, 1, 1, 8'h40, 1, 8'hFD, 0, 24'hC00002, 8'h02, 0, 0, 8'h40));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00040, 8'h40, 1, 0, 8'h41));
      // halt at instr_pc 3 while stalled, then drain
      vq.push_back(mk(0, 1, 1, 8'h03, 0, 8'h00, 0, 24'hC00040, 8'h40, 0, 0, 8'h03));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00003, 8'h03, 1, 0, 8'h04));
      vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 24'hC00003, 8'h03, 1, 1, 8'h04));
      vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 24'hC00003, 8'h03, 1, 1, 8'h04));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00003, 8'h03, 0, 1, 8'h04));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00003, 8'h03, 0, 1, 8'h04));
      // branch ignored while halted
      vq.push_back(mk(0, 1, 0, 8'h00, 1, 8'h10, 0, 24'hC00003, 8'h03, 0, 1, 8'h04));
      // reset out of HALTED
      vq.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 24'h000000, 8'h00, 0, 0, 8'h00));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00000, 8'h00, 1, 0, 8'h01));
      // branch with nothing valid is ignored; fetch proceeds
      vq.push_back(mk(0, 1, 1, 8'h20, 0, 8'h00, 0, 24'hC00000, 8'h00, 0, 0, 8'h20));
      vq.push_back(mk(0, 1, 0, 8'h00, 1, 8'h05, 0, 24'hC00020, 8'h20, 1, 0, 8'h21));
      // halt with ready=1 drops valid at once; jump resumes
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 24'hC00020, 8'h20, 0, 1, 8'h21));
      vq.push_back(mk(0, 1, 1, 8'h80, 0, 8'h00, 1, 24'hC00020, 8'h20, 0, 0, 8'h80));
      vq.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 24'hC00080, 8'h80, 1, 0, 8'h81));
      // redirect while stalled discards the held instruction
      vq.push_back(mk(0, 0, 1, 8'h10, 0, 8'h00, 0, 24'hC00080, 8'h80, 0, 0, 8'h10));

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].rdy, vq[i].jen, vq[i].ja, vq[i].ben, vq[i].bo, vq[i].hlt);
         expect_out($sformatf("vec%0d", i), vq[i].e_instr, vq[i].e_ipc, vq[i].e_v,
                    vq[i].e_h, vq[i].e_ra);
      end

      // reset asserted mid-stall clears the held instruction
      drive(0, 1, 0, 8'h00, 0, 8'h00, 0);
      expect_out("stall_rst.fetch", 24'hC00010, 8'h10, 1, 0, 8'h11);
      drive(0, 0, 0, 8'h00, 0, 8'h00, 0);
      expect_out("stall_rst.hold", 24'hC00010, 8'h10, 1, 0, 8'h11);
      drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
      expect_out("stall_rst.rst", 24'h000000, 8'h00, 0, 0, 8'h00);
      drive(0, 1, 0, 8'h00, 0, 8'h00, 0);
      expect_out("stall_rst.first", 24'hC00000, 8'h00, 1, 0, 8'h01);

      // branch while stalled wins; pc = instr_pc(1) + 0x7F
      drive(0, 1, 0, 8'h00, 0, 8'h00, 0);
      expect_out("stall_br.fetch", 24'hC00001, 8'h01, 1, 0, 8'h02);
      drive(0, 0, 0, 8'h00, 1, 8'h7F, 0);
      expect_out("stall_br.redir", 24'hC00001, 8'h01, 0, 0, 8'h80);
      drive(0, 1, 0, 8'h00, 0, 8'h00, 0);
      expect_out("stall_br.target", 24'hC00080, 8'h80, 1, 0, 8'h81);

      // halt held high in HALTED is ignored; stays frozen
      drive(0, 1, 0, 8'h00, 0, 8'h00, 1);
      expect_out("halt_hold.enter", 24'hC00080, 8'h80, 0, 1, 8'h81);
      drive(0, 1, 0, 8'h00, 0, 8'h00, 1);
      expect_out("halt_hold.stay", 24'hC00080, 8'h80, 0, 1, 8'h81);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
